// File: rtl/brctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brctl_pkg
// Description : Shared definitions for the branch controller: the 8-bit
//               address width, the branch opcode encoding and a helper that
//               forms the return address of a CALL.
// Revision    : 1.0 - initial release
// ============================================================================
package brctl_pkg;

  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  // Opcodes 3'b110 and 3'b111 are reserved and decode as OP_NONE.
  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_JNZ  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } op_e;

  // Address of the instruction after a CALL; wraps 8'hFF -> 8'h00.
  function automatic logic [ADDR_W-1:0] ret_addr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_ONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : LIFO return-address stack, DEPTH entries of W bits.
//               Push is ignored when full, pop is ignored when empty.
//               Only the entry count is reset; contents are don't-care.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push_i, wdata_i - push request and data
//               pop_i           - pop request
//               top_o           - most recently pushed entry (valid if !empty)
//               count_o         - number of valid entries, 0..DEPTH
//               full_o, empty_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             top_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_top_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the low bits of the count address the next
  // free slot; when full they alias slot 0 but pushes are blocked then.
  assign w_wr_idx  = count_q[PW-1:0];
  assign w_top_idx = w_wr_idx - PW'(1);
  assign top_o     = mem_q[w_top_idx];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (w_do_push) begin
      count_d = count_q + CW'(1);
    end else if (w_do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      mem_q[w_wr_idx] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl
// Description : Branch decode for an 8-bit program counter. Produces a
//               combinational load strobe and load address so the program
//               counter captures them on the same rising edge. CALL/RET use
//               a return-address stack (ret_stack) when the call stack is
//               enabled.
// Config      : BRCTL_CALL_STACK_EN - when defined, CALL pushes pc+1 and RET
//               pops it; when undefined there is no stack, CALL acts as JMP,
//               RET acts as NONE and depth/ovf/unf are tied to 0.
// Ports       : clk, reset - clock, synchronous active-high reset
//               pc, op, target, z - current instruction context
//               load, k   - program-counter load strobe and address
//               depth     - valid stack entries
//               ovf, unf  - sticky CALL-when-full / RET-when-empty flags
// Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl
  import brctl_pkg::*;
#(
  parameter int               DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              z,
  output logic              load,
  output logic [ADDR_W-1:0] k,
  output logic [4:0]        depth,
  output logic              ovf,
  output logic              unf
);

  logic              w_load;
  logic [ADDR_W-1:0] w_k;

`ifdef BRCTL_CALL_STACK_EN
  logic                    w_push;
  logic                    w_pop;
  logic                    w_ovf_set;
  logic                    w_unf_set;
  logic [ADDR_W-1:0]       w_top;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    ovf_q;
  logic                    unf_q;

  ret_stack #(
    .DEPTH (DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (ret_addr(pc)),
    .top_o   (w_top),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    w_load    = 1'b0;
    w_k       = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (reset) begin
      // Reset overrides any opcode; stack requests are dropped.
      w_load = 1'b1;
      w_k    = RESET_VEC;
    end else begin
      case (op)
        OP_JMP: begin
          w_load = 1'b1;
          w_k    = target;
        end
        OP_JZ: begin
          w_load = z;
          w_k    = z ? target : '0;
        end
        OP_JNZ: begin
          w_load = ~z;
          w_k    = z ? '0 : target;
        end
        OP_CALL: begin
          // The jump is always taken; only the push depends on room.
          w_load    = 1'b1;
          w_k       = target;
          w_push    = ~w_full;
          w_ovf_set = w_full;
        end
        OP_RET: begin
          if (!w_empty) begin
            w_load = 1'b1;
            w_k    = w_top;
            w_pop  = 1'b1;
          end else begin
            w_unf_set = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | w_ovf_set;
      unf_q <= unf_q | w_unf_set;
    end
  end

  assign depth = 5'(w_count);
  assign ovf   = ovf_q;
  assign unf   = unf_q;
`else
  // No stack: the clock, pc and DEPTH have no function in this build.
  localparam int unused_depth = DEPTH;
  logic unused_sigs;
  assign unused_sigs = ^{clk, pc};

  always_comb begin
    w_load = 1'b0;
    w_k    = '0;
    if (reset) begin
      w_load = 1'b1;
      w_k    = RESET_VEC;
    end else begin
      case (op)
        OP_JMP, OP_CALL: begin
          w_load = 1'b1;
          w_k    = target;
        end
        OP_JZ: begin
          w_load = z;
          w_k    = z ? target : '0;
        end
        OP_JNZ: begin
          w_load = ~z;
          w_k    = z ? '0 : target;
        end
        default: begin
        end
      endcase
    end
  end

  assign depth = '0;
  assign ovf   = 1'b0;
  assign unf   = 1'b0;
`endif

  assign load = w_load;
  assign k    = w_k;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Self-checking bench for branch_ctrl. A behavioural model of
//               the branch/stack rules pushes the expected outputs for each
//               driven cycle into a scoreboard queue; each test pops and
//               compares before the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;
  import brctl_pkg::*;

  localparam int          TB_DEPTH = 4;
  localparam logic [7:0]  TB_RVEC  = 8'h00;
`ifdef BRCTL_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  typedef struct packed {
    logic       r;
    logic [2:0] op;
    logic [7:0] pc;
    logic [7:0] tg;
    logic       z;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic [2:0] op;
  logic [7:0] target;
  logic       z;
  logic       load;
  logic [7:0] k;
  logic [4:0] depth;
  logic       ovf;
  logic       unf;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {load, k, depth, ovf, unf}
  logic [15:0] sb[$];
  logic [15:0] exp_v;
  logic [15:0] obs_v;

  // Reference model state
  logic [7:0] m_stack [16];
  int         m_depth = 0;
  logic       m_ovf   = 1'b0;
  logic       m_unf   = 1'b0;
  int         n_depth;
  logic       n_ovf;
  logic       n_unf;

  branch_ctrl #(
    .DEPTH     (TB_DEPTH),
    .RESET_VEC (TB_RVEC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pc     (pc),
    .op     (op),
    .target (target),
    .z      (z),
    .load   (load),
    .k      (k),
    .depth  (depth),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic r, input logic [2:0] o,
                               input logic [7:0] p, input logic [7:0] t,
                               input logic zz);
    stim_t s;
    s.r = r; s.op = o; s.pc = p; s.tg = t; s.z = zz;
    return s;
  endfunction

  // Drive one cycle's inputs and push the model's expectation.
  task automatic apply(input stim_t s);
    logic       e_load;
    logic [7:0] e_k;
    reset  = s.r;
    op     = s.op;
    pc     = s.pc;
    target = s.tg;
    z      = s.z;
    e_load  = 1'b0;
    e_k     = 8'h00;
    n_depth = m_depth;
    n_ovf   = m_ovf;
    n_unf   = m_unf;
    if (s.r) begin
      e_load  = 1'b1;
      e_k     = TB_RVEC;
      n_depth = 0;
      n_ovf   = 1'b0;
      n_unf   = 1'b0;
    end else begin
      case (s.op)
        3'b001: begin e_load = 1'b1; e_k = s.tg; end
        3'b010: if (s.z)  begin e_load = 1'b1; e_k = s.tg; end
        3'b011: if (!s.z) begin e_load = 1'b1; e_k = s.tg; end
        3'b100: begin
          e_load = 1'b1;
          e_k    = s.tg;
          if (STACK_EN) begin
            if (m_depth == TB_DEPTH) begin
              n_ovf = 1'b1;
            end else begin
              m_stack[m_depth] = s.pc + 8'd1;
              n_depth = m_depth + 1;
            end
          end
        end
        3'b101: begin
          if (STACK_EN) begin
            if (m_depth > 0) begin
              e_load  = 1'b1;
              e_k     = m_stack[m_depth-1];
              n_depth = m_depth - 1;
            end else begin
              n_unf = 1'b1;
            end
          end
        end
        default: begin end
      endcase
    end
    sb.push_back({e_load, e_k, 5'(m_depth), m_ovf, m_unf});
  endtask

  task automatic advance();
    @(posedge clk);
    m_depth = n_depth;
    m_ovf   = n_ovf;
    m_unf   = n_unf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    // First edge: DUT state is unknown until reset has been sampled, so only
    // the combinational reset override is compared here.
    apply(mk(1'b1, OP_JMP, 8'h33, 8'h40, 1'b0));
    #1;
    exp_v = sb.pop_front();
    obs_v = {load, k, depth, ovf, unf};
    total++;
    if (obs_v[15:7] !== exp_v[15:7]) begin
      bad++;
      $display("FAIL reset_override got=%h exp=%h", obs_v[15:7], exp_v[15:7]);
    end
    advance();
    begin
      stim_t s[$];
      s.push_back(mk(1'b1, OP_JMP,  8'h33, 8'h40, 1'b0));
      s.push_back(mk(1'b1, OP_RET,  8'h10, 8'h40, 1'b1));
      s.push_back(mk(1'b0, OP_NONE, 8'h00, 8'h40, 1'b0));
      s.push_back(mk(1'b0, OP_JMP,  8'h01, 8'h40, 1'b0));
      foreach (s[i]) begin
        apply(s[i]);
        #1;
        exp_v = sb.pop_front();
        obs_v = {load, k, depth, ovf, unf};
        total++;
        if (obs_v !== exp_v) begin
          bad++;
          $display("FAIL reset[%0d] got=%h exp=%h", i, obs_v, exp_v);
        end
        advance();
      end
    end
  endtask

  task automatic test_cond();
    stim_t s[$];
    s.push_back(mk(1'b0, OP_JZ,   8'h02, 8'h20, 1'b1));
    s.push_back(mk(1'b0, OP_JNZ,  8'h03, 8'h20, 1'b1));
    s.push_back(mk(1'b0, OP_JZ,   8'h04, 8'h20, 1'b0));
    s.push_back(mk(1'b0, OP_JNZ,  8'h05, 8'h20, 1'b0));
    s.push_back(mk(1'b0, 3'b110,  8'h06, 8'h77, 1'b1));
    s.push_back(mk(1'b0, 3'b111,  8'h07, 8'h77, 1'b0));
    s.push_back(mk(1'b0, OP_NONE, 8'h08, 8'h77, 1'b1));
    s.push_back(mk(1'b0, OP_JMP,  8'h09, 8'hFE, 1'b1));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      exp_v = sb.pop_front();
      obs_v = {load, k, depth, ovf, unf};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL cond[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_call_ret();
    stim_t s[$];
    s.push_back(mk(1'b1, OP_NONE, 8'h00, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_CALL, 8'h10, 8'h80, 1'b0));
    s.push_back(mk(1'b0, OP_CALL, 8'h85, 8'hA0, 1'b0));
    s.push_back(mk(1'b0, OP_RET,  8'hA3, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_RET,  8'h90, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_NONE, 8'h11, 8'h00, 1'b0));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      exp_v = sb.pop_front();
      obs_v = {load, k, depth, ovf, unf};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL call_ret[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_overflow();
    stim_t s[$];
    s.push_back(mk(1'b1, OP_NONE, 8'h00, 8'h00, 1'b0));
    for (int n = 0; n < 5; n++)
      s.push_back(mk(1'b0, OP_CALL, 8'(8'h30 + 8'(n * 16)), 8'(8'hC0 + 8'(n)), 1'b0));
    for (int n = 0; n < 4; n++)
      s.push_back(mk(1'b0, OP_RET, 8'h00, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_NONE, 8'h00, 8'h00, 1'b0));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      exp_v = sb.pop_front();
      obs_v = {load, k, depth, ovf, unf};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL overflow[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_underflow();
    stim_t s[$];
    s.push_back(mk(1'b1, OP_NONE, 8'h00, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_RET,  8'h12, 8'h55, 1'b0));
    s.push_back(mk(1'b0, OP_CALL, 8'h20, 8'h60, 1'b0));
    s.push_back(mk(1'b0, OP_RET,  8'h61, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_JMP,  8'h21, 8'h70, 1'b0));
    s.push_back(mk(1'b1, OP_RET,  8'h00, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_NONE, 8'h00, 8'h00, 1'b0));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      exp_v = sb.pop_front();
      obs_v = {load, k, depth, ovf, unf};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL underflow[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    stim_t s[$];
    s.push_back(mk(1'b0, OP_CALL, 8'hFF, 8'h05, 1'b0));
    s.push_back(mk(1'b0, OP_RET,  8'h05, 8'h00, 1'b0));
    s.push_back(mk(1'b0, OP_NONE, 8'h00, 8'h00, 1'b0));
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      exp_v = sb.pop_front();
      obs_v = {load, k, depth, ovf, unf};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL wrap[%0d] got=%h exp=%h", i, obs_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 300; i++) begin
      s = mk(($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)),
             8'($urandom), 8'($urandom), 1'($urandom));
      apply(s);
      #1;
      exp_v = sb.pop_front();
      obs_v = {load, k, depth, ovf, unf};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL b2b[%0d] op=%0d got=%h exp=%h", i, s.op, obs_v, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    reset  = 1'b1;
    op     = 3'b000;
    pc     = 8'h00;
    target = 8'h00;
    z      = 1'b0;
    @(negedge clk);
    test_reset();
    test_cond();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
